// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator entry controller.
// Operator codes are one-hot; phase codes drive the status LEDs.
package calc_pkg;

    typedef enum logic [1:0] {
        GET_A  = 2'b00,
        GET_OP = 2'b01,
        GET_B  = 2'b10,
        SHOW   = 2'b11
    } state_t;

    localparam logic [0:3] OP_ADD  = 4'b1000;
    localparam logic [0:3] OP_SUB  = 4'b0100;
    localparam logic [0:3] OP_MUL  = 4'b0010;
    localparam logic [0:3] OP_DIV  = 4'b0001;
    localparam logic [0:3] OP_NONE = 4'b0000;

    localparam logic [0:1] PH_GET_A  = 2'b00;
    localparam logic [0:1] PH_GET_OP = 2'b01;
    localparam logic [0:1] PH_GET_B  = 2'b10;
    localparam logic [0:1] PH_SHOW   = 2'b11;

    function automatic logic is_onehot(input logic [0:3] v);
        return (v != OP_NONE) && ((v & (v - 4'd1)) == OP_NONE);
    endfunction

    function automatic logic [0:1] phase_of(input state_t s);
        logic [0:1] ph;
        ph = PH_GET_A;
        unique case (s)
            GET_A:  ph = PH_GET_A;
            GET_OP: ph = PH_GET_OP;
            GET_B:  ph = PH_GET_B;
            SHOW:   ph = PH_SHOW;
            default: ph = PH_GET_A;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector for a
// push-button; a button already high at reset release is ignored.
module key_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic pulse
);

    logic       s1;
    logic       s2;
    logic       s3;
    logic [1:0] fill;
    logic       armed;

    // Arm only after the settled input has been seen low at least once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            fill  <= 2'b00;
            armed <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= key;
            s2    <= s1;
            s3    <= s2;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & ~s2);
            pulse <= s2 & ~s3 & armed;
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Operand/operator entry FSM for a small calculator: collects A, OP and B
// from switches on enter presses, then shows the result until enter/timeout.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:2] key_val,
    input  logic [0:3] op_sel,
    input  logic       key_enter,
    input  logic       key_clear,
    output logic [0:2] in_1,
    output logic [0:2] in_2,
    output logic [0:3] oper,
    output logic [0:1] phase,
    output logic       err
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

    state_t          state;
    logic [0:2]      a;
    logic [0:2]      b;
    logic [0:3]      op;
    logic [CW-1:0]   cnt;
    logic            rej;
    logic            enter;
    logic            clear;

    key_sync_edge u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_enter),
        .pulse (enter)
    );

    key_sync_edge u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_clear),
        .pulse (clear)
    );

    // Clear shares the reset path so it always wins over enter.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state <= GET_A;
            a     <= 3'b000;
            b     <= 3'b000;
            op    <= OP_NONE;
            cnt   <= '0;
            rej   <= 1'b0;
        end else begin
            rej <= 1'b0;
            unique case (state)
                GET_A: begin
                    if (enter) begin
                        a     <= key_val;
                        state <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (enter) begin
                        if (is_onehot(op_sel)) begin
                            op    <= op_sel;
                            state <= GET_B;
                        end else begin
                            rej <= 1'b1;
                        end
                    end
                end
                GET_B: begin
                    if (enter) begin
                        b     <= key_val;
                        cnt   <= '0;
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    if (enter || cnt == TERM) begin
                        a     <= 3'b000;
                        b     <= 3'b000;
                        op    <= OP_NONE;
                        cnt   <= '0;
                        state <= GET_A;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= GET_A;
            endcase
        end
    end

    assign in_1  = a;
    assign in_2  = b;
    assign oper  = (state == SHOW) ? op : OP_NONE;
    assign phase = phase_of(state);
    assign err   = rej
                 | ((state == SHOW) && (op == OP_DIV) && (b == 3'b000));

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed scenarios then random presses,
// checked against an event-level model of the entry sequence.
module tb_calc_entry_ctrl;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:2] key_val = 3'b000;
    logic [0:3] op_sel = 4'b0000;
    logic       key_enter = 1'b0;
    logic       key_clear = 1'b0;
    logic [0:2] in_1;
    logic [0:2] in_2;
    logic [0:3] oper;
    logic [0:1] phase;
    logic       err;

    int checks = 0;
    int failures = 0;

    int m_ph;
    int m_a;
    int m_b;
    int m_op;

    calc_entry_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_val   (key_val),
        .op_sel    (op_sel),
        .key_enter (key_enter),
        .key_clear (key_clear),
        .in_1      (in_1),
        .in_2      (in_2),
        .oper      (oper),
        .phase     (phase),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        m_ph = 0;
        m_a  = 0;
        m_b  = 0;
        m_op = 0;
    endtask

    task automatic chk_outs(input string tag);
        int e_err;
        int e_oper;
        e_oper = (m_ph == 3) ? m_op : 0;
        e_err  = (m_ph == 3 && m_op == 1 && m_b == 0) ? 1 : 0;
        chk({tag, ".phase"}, 32'(phase), 32'(m_ph));
        chk({tag, ".in_1"}, 32'(in_1), 32'(m_a));
        chk({tag, ".in_2"}, 32'(in_2), 32'(m_b));
        chk({tag, ".oper"}, 32'(oper), 32'(e_oper));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
    endtask

    // Model of one accepted button event.
    task automatic model_event(input bit en, input bit cl);
        if (cl) begin
            model_zero();
        end else if (en) begin
            case (m_ph)
                0: begin
                    m_a  = int'(key_val);
                    m_ph = 1;
                end
                1: begin
                    if ($countones(op_sel) == 1) begin
                        m_op = int'(op_sel);
                        m_ph = 2;
                    end
                end
                2: begin
                    m_b  = int'(key_val);
                    m_ph = 3;
                end
                default: model_zero();
            endcase
        end
    endtask

    task automatic press(input bit en, input bit cl, input string tag);
        int pre_ph;
        int errs;
        int e_errs;
        pre_ph = m_ph;
        errs = 0;
        e_errs = (en && !cl && pre_ph == 1
                  && $countones(op_sel) != 1) ? 1 : 0;
        key_enter = en;
        key_clear = cl;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            errs += int'(err);
        end
        key_enter = 1'b0;
        key_clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            errs += int'(err);
        end
        if (pre_ph <= 1)
            chk({tag, ".errcnt"}, 32'(errs), 32'(e_errs));
        model_event(en, cl);
        chk_outs(tag);
    endtask

    task automatic enter_val(input logic [0:2] v, input string tag);
        key_val = v;
        press(1'b1, 1'b0, tag);
    endtask

    task automatic enter_op(input logic [0:3] o, input string tag);
        op_sel = o;
        press(1'b1, 1'b0, tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        model_zero();
    endtask

    initial begin
        bit cl;
        model_zero();
        do_reset();
        chk_outs("reset");

        enter_val(3'b011, "add_a");
        enter_op(4'b1000, "add_op");
        enter_val(3'b101, "add_b");
        enter_val(3'b000, "add_exit");

        enter_val(3'b010, "rej_a");
        enter_op(4'b1100, "rej_op");
        enter_op(4'b0000, "rej_zero");
        enter_op(4'b0001, "rej_ok");
        enter_val(3'b001, "rej_b");
        enter_val(3'b000, "rej_exit");

        enter_val(3'b110, "dz_a");
        enter_op(4'b0001, "dz_op");
        enter_val(3'b000, "dz_b");
        tick(5);
        chk_outs("dz_hold");
        enter_val(3'b000, "dz_exit");

        enter_val(3'b100, "to_a");
        enter_op(4'b0100, "to_op");
        enter_val(3'b010, "to_b");
        tick(11);
        chk_outs("to_before");
        tick(1);
        model_zero();
        chk_outs("to_after");

        enter_val(3'b101, "clr_a");
        enter_op(4'b1000, "clr_op");
        key_val = 3'b011;
        press(1'b1, 1'b1, "clr_both");

        enter_val(3'b111, "mid_a");
        enter_op(4'b0010, "mid_op");
        do_reset();
        chk_outs("mid_reset");

        rst_n = 1'b0;
        key_enter = 1'b1;
        key_val = 3'b010;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        chk_outs("held_high");
        key_enter = 1'b0;
        tick(4);
        chk_outs("held_fall");
        enter_val(3'b010, "held_press");

        for (int i = 0; i < 60; i++) begin
            key_val = 3'($urandom);
            if ($urandom_range(0, 99) < 70)
                op_sel = 4'b1000 >> $urandom_range(0, 3);
            else
                op_sel = 4'($urandom);
            cl = ($urandom_range(0, 9) == 0);
            press(1'b1, cl, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
